// File: rtl/shift_register_universal.sv
// ---------------------------------------------------------------------------
// shift_register_universal
//
// WIDTH-bit universal storage/serialiser register. It supports parallel load,
// logical shifts left and right, rotates left and right, and an arithmetic
// shift right. It also has a clock enable, a synchronous clear and preset
// with fixed priority, a registered shifted-out bit and a zero flag.
//
// Parameters:
//   WIDTH         register width in bits (2..64)
//   RESET_VALUE   contents forced by the asynchronous reset
//   PRESET_VALUE  contents loaded by the synchronous preset
//
// Ports:
//   i_CLOCK_POS       rising-edge clock
//   i_RESET_POS       asynchronous active-high reset
//   i_CLEAR           synchronous clear to zero (beats preset)
//   i_PRESET          synchronous load of PRESET_VALUE
//   i_ENABLE          enable for the i_MODE operations
//   i_MODE            000 hold, 001 load, 010 shl, 011 shr,
//                     100 rol, 101 ror, 110 asr, 111 hold
//   i_SIGNAL_IN       parallel load data
//   i_SERIAL_LEFT     bit entering at bit 0 on shift left
//   i_SERIAL_RIGHT    bit entering at bit WIDTH-1 on shift right
//   o_SIGNAL_OUT      register contents
//   o_SIGNAL_OUT_NEG  bitwise complement of the contents
//   o_SHIFT_OUT       bit most recently shifted or rotated out
//   o_ZERO            high when the contents are all zero
// ---------------------------------------------------------------------------
module shift_register_universal #(
  parameter int                 WIDTH        = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]   PRESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             i_CLOCK_POS,
  input  logic             i_RESET_POS,
  input  logic             i_CLEAR,
  input  logic             i_PRESET,
  input  logic             i_ENABLE,
  input  logic [2:0]       i_MODE,
  input  logic [WIDTH-1:0] i_SIGNAL_IN,
  input  logic             i_SERIAL_LEFT,
  input  logic             i_SERIAL_RIGHT,
  output logic [WIDTH-1:0] o_SIGNAL_OUT,
  output logic [WIDTH-1:0] o_SIGNAL_OUT_NEG,
  output logic             o_SHIFT_OUT,
  output logic             o_ZERO
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_next_s;
  logic             shift_out_r;
  logic             shift_out_next_s;
  mode_e            mode_s;

  assign mode_s = mode_e'(i_MODE);

  // Next-state selection: clear > preset > enabled mode operation > hold.
  always_comb begin
    data_next_s      = data_r;
    shift_out_next_s = shift_out_r;
    if (i_CLEAR) begin
      data_next_s = {WIDTH{1'b0}};
    end else if (i_PRESET) begin
      data_next_s = PRESET_VALUE;
    end else if (i_ENABLE) begin
      case (mode_s)
        MODE_HOLD: begin
          data_next_s = data_r;
        end
        MODE_LOAD: begin
          data_next_s = i_SIGNAL_IN;
        end
        MODE_SHL: begin
          data_next_s      = {data_r[WIDTH-2:0], i_SERIAL_LEFT};
          shift_out_next_s = data_r[WIDTH-1];
        end
        MODE_SHR: begin
          data_next_s      = {i_SERIAL_RIGHT, data_r[WIDTH-1:1]};
          shift_out_next_s = data_r[0];
        end
        MODE_ROL: begin
          data_next_s      = {data_r[WIDTH-2:0], data_r[WIDTH-1]};
          shift_out_next_s = data_r[WIDTH-1];
        end
        MODE_ROR: begin
          data_next_s      = {data_r[0], data_r[WIDTH-1:1]};
          shift_out_next_s = data_r[0];
        end
        MODE_ASR: begin
          // Sign bit is replicated into the vacated MSB.
          data_next_s      = {data_r[WIDTH-1], data_r[WIDTH-1:1]};
          shift_out_next_s = data_r[0];
        end
        MODE_RSVD: begin
          data_next_s = data_r;
        end
        default: begin
          data_next_s = data_r;
        end
      endcase
    end else begin
      data_next_s      = data_r;
      shift_out_next_s = shift_out_r;
    end
  end

  // State register; asynchronous reset aborts any in-flight operation.
  always_ff @(posedge i_CLOCK_POS or posedge i_RESET_POS) begin
    if (i_RESET_POS) begin
      data_r      <= RESET_VALUE;
      shift_out_r <= 1'b0;
    end else begin
      data_r      <= data_next_s;
      shift_out_r <= shift_out_next_s;
    end
  end

  assign o_SIGNAL_OUT     = data_r;
  assign o_SIGNAL_OUT_NEG = ~data_r;
  assign o_SHIFT_OUT      = shift_out_r;
  assign o_ZERO           = (data_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal (WIDTH=8, RESET_VALUE=8'hA5).
// The reference model uses plain integer arithmetic on the register value.
module tb_shift_register_universal;

  localparam int          W      = 8;
  localparam logic [7:0]  RV     = 8'hA5;
  localparam int          MASK   = 255;
  localparam int          MSB    = 128;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       pre;
  logic       en;
  logic [2:0] mode;
  logic [7:0] din;
  logic       sl;
  logic       sr;
  logic [7:0] q_out;
  logic [7:0] q_neg;
  logic       so_out;
  logic       zero_out;

  int checks;
  int failures;

  // reference model state
  int m_q;
  int m_so;

  shift_register_universal #(
    .WIDTH        (W),
    .RESET_VALUE  (RV),
    .PRESET_VALUE (8'hFF)
  ) dut (
    .i_CLOCK_POS      (clk),
    .i_RESET_POS      (rst),
    .i_CLEAR          (clr),
    .i_PRESET         (pre),
    .i_ENABLE         (en),
    .i_MODE           (mode),
    .i_SIGNAL_IN      (din),
    .i_SERIAL_LEFT    (sl),
    .i_SERIAL_RIGHT   (sr),
    .o_SIGNAL_OUT     (q_out),
    .o_SIGNAL_OUT_NEG (q_neg),
    .o_SHIFT_OUT      (so_out),
    .o_ZERO           (zero_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_value({tag, ".q"},    64'(q_out),    64'(m_q));
    check_value({tag, ".neg"},  64'(q_neg),    64'((~m_q) & MASK));
    check_value({tag, ".so"},   64'(so_out),   64'(m_so));
    check_value({tag, ".zero"}, 64'(zero_out), 64'(m_q == 0));
  endtask

  // Reference model of one clock edge, driven by the current inputs.
  task automatic model_edge();
    int q;
    q = m_q;
    if (clr) begin
      m_q = 0;
    end else if (pre) begin
      m_q = MASK;
    end else if (en) begin
      case (mode)
        3'd1: m_q = int'(din);
        3'd2: begin m_so = (q / MSB) % 2; m_q = (q * 2 + int'(sl)) % 256; end
        3'd3: begin m_so = q % 2; m_q = q / 2 + int'(sr) * MSB; end
        3'd4: begin m_so = (q / MSB) % 2; m_q = (q * 2 + m_so) % 256; end
        3'd5: begin m_so = q % 2; m_q = q / 2 + m_so * MSB; end
        3'd6: begin m_so = q % 2; m_q = q / 2 + (q / MSB) * MSB; end
        default: m_q = q;
      endcase
    end
  endtask

  // One clock: model follows the edge, outputs are sampled on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic c, input logic p, input logic e, input logic [2:0] m,
                       input logic [7:0] d, input logic l, input logic r);
    clr = c; pre = p; en = e; mode = m; din = d; sl = l; sr = r;
  endtask

  // Asynchronous reset pulse placed between edges (called just after a negedge).
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    m_q = int'(RV);
    m_so = 0;
    check_all(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_q = 0;
    m_so = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);

    // Reset with no clock edge.
    async_reset("reset");

    // Load 81, shift left x3 with serial 1.
    drive(1'b0, 1'b0, 1'b1, 3'd1, 8'h81, 1'b1, 1'b0);
    step("load81");
    drive(1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("shl");
    check_value("shl_final", 64'(q_out), 64'h0F);

    // Load 81, rotate right, arithmetic shift right x2.
    drive(1'b0, 1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
    step("load81b");
    drive(1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 1'b1, 1'b1);
    step("ror");
    check_value("ror_const", 64'(q_out), 64'hC0);
    drive(1'b0, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
    step("asr1");
    step("asr2");
    check_value("asr_const", 64'(q_out), 64'hF0);

    // Clear beats preset and load; then preset alone.
    drive(1'b1, 1'b1, 1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
    step("clr_pre");
    check_value("clr_zero", 64'(zero_out), 64'd1);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    step("preset");
    check_value("preset_const", 64'(q_out), 64'hFF);

    // Enable low holds; reserved mode holds.
    drive(1'b0, 1'b0, 1'b1, 3'd1, 8'h12, 1'b0, 1'b0);
    step("load12");
    drive(1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step("en_off");
    drive(1'b0, 1'b0, 1'b1, 3'd7, 8'hFF, 1'b1, 1'b1);
    step("rsvd");
    check_value("rsvd_const", 64'(q_out), 64'h12);

    // Continuous shift right, reset between edges, then resume.
    drive(1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
    step("shr1");
    step("shr2");
    drive(1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    async_reset("mid_reset");
    step("after_reset");
    check_value("after_reset_const", 64'(q_out), 64'h52);
    check_value("after_reset_so", 64'(so_out), 64'd1);

    // Randomized operation against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 5) != 0) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)),
            8'($urandom),
            1'($urandom),
            1'($urandom));
      if ($urandom_range(0, 49) == 0) async_reset("rand_reset");
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_register_universal.md
# shift_register_universal

Parametrised WIDTH-bit universal register: the multi-bit successor of the library's single-bit D flip-flop. Adds parallel load, left/right shift, rotate, arithmetic shift, clock enable, synchronous clear/preset with fixed priority, a registered shifted-out bit and a zero flag. Serves as the general storage and serialiser element for counters, LFSR wrappers and serial links built from the module library.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded by the asynchronous reset.
- PRESET_VALUE, {WIDTH{1'b1}}, value loaded by the synchronous preset.

Ports:
- i_CLOCK_POS  in  1  single clock; all state changes on its rising edge.
- i_RESET_POS  in  1  asynchronous, active-high reset.
- i_CLEAR  in  1  synchronous clear to all zeros.
- i_PRESET  in  1  synchronous load of PRESET_VALUE.
- i_ENABLE  in  1  clock enable for mode operations.
- i_MODE  in  3  operation select (see Operation).
- i_SIGNAL_IN  in  WIDTH  parallel load data.
- i_SERIAL_LEFT  in  1  bit entering at bit 0 on shift-left.
- i_SERIAL_RIGHT  in  1  bit entering at bit WIDTH-1 on shift-right.
- o_SIGNAL_OUT  out  WIDTH  register contents.
- o_SIGNAL_OUT_NEG  out  WIDTH  bitwise complement of o_SIGNAL_OUT.
- o_SHIFT_OUT  out  1  bit most recently shifted or rotated out.
- o_ZERO  out  1  high when o_SIGNAL_OUT == 0.

## Operation
- Priority per edge: i_RESET_POS (async) > i_CLEAR > i_PRESET > i_ENABLE/i_MODE.
- i_CLEAR and i_PRESET act regardless of i_ENABLE. When both are high, clear wins. Both leave o_SHIFT_OUT unchanged.
- With i_ENABLE=0, the register and o_SHIFT_OUT hold.
- i_MODE with i_ENABLE=1 (Q = current value):
  - 000 hold.
  - 001 load: Q <= i_SIGNAL_IN.
  - 010 shift left: Q <= {Q[W-2:0], i_SERIAL_LEFT}; o_SHIFT_OUT <= Q[W-1].
  - 011 shift right: Q <= {i_SERIAL_RIGHT, Q[W-1:1]}; o_SHIFT_OUT <= Q[0].
  - 100 rotate left: Q <= {Q[W-2:0], Q[W-1]}; o_SHIFT_OUT <= Q[W-1].
  - 101 rotate right: Q <= {Q[0], Q[W-1:1]}; o_SHIFT_OUT <= Q[0].
  - 110 arithmetic shift right: Q <= {Q[W-1], Q[W-1:1]}; o_SHIFT_OUT <= Q[0].
  - 111 reserved; behaves as hold.
- In hold and load modes, o_SHIFT_OUT is unchanged.
- o_SIGNAL_OUT_NEG and o_ZERO are combinational from the register. They have no extra state.

## Timing
- Reset: asserting i_RESET_POS immediately (no clock needed) forces:
  - o_SIGNAL_OUT = RESET_VALUE
  - o_SIGNAL_OUT_NEG = ~RESET_VALUE
  - o_SHIFT_OUT = 0
  - o_ZERO = (RESET_VALUE == 0)
- Reset mid-operation aborts the operation. No partial shift survives.
- After reset deasserts, the first rising edge performs a normal operation. Deassertion is synchronised externally.
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N. Combinational outputs follow in the same cycle.
- Throughput is one operation per clock. A sustained shift moves one bit per cycle. Shift and rotate have no wrap beyond the stated bit mapping.
- The serial inputs are ignored in every mode except their own shift direction.

## Test plan
- Reset with WIDTH=8 and RESET_VALUE=8'hA5 -> outputs 8'hA5 and 8'h5A asynchronously, with no clock edge; o_SHIFT_OUT=0; o_ZERO=0.
- Load 8'h81, then shift left 3 cycles with i_SERIAL_LEFT=1 -> 8'h03, 8'h07, 8'h0F; o_SHIFT_OUT = 1, 0, 0.
- Load 8'h81, then rotate right 1 cycle -> 8'hC0 with o_SHIFT_OUT=1. Then arithmetic shift right 2 cycles -> 8'hE0, then 8'hF0.
- i_CLEAR=1, i_PRESET=1 and i_MODE=load of 8'h3C on the same edge -> 8'h00 and o_ZERO=1. Next edge, with i_PRESET only -> 8'hFF.
- Load 8'h12, then i_ENABLE=0 with i_MODE=010 for 4 cycles -> holds 8'h12 and o_SHIFT_OUT unchanged. Then i_MODE=111 with enable -> still 8'h12.
- Shift right continuously, then assert i_RESET_POS between edges -> outputs jump to RESET_VALUE at once. The first edge after release applies the current mode to RESET_VALUE.
